// File: rtl/ara_dispatch_buffer.sv
// Request FIFO between the vector dispatcher and Ara's accelerator port.
// It also gates response-expecting instructions on an in-flight limit and keeps stall statistics.
module ara_dispatch_buffer #(
   parameter int unsigned Depth          = 4,
   parameter int unsigned XLEN           = 64,
   parameter int unsigned MaxOutstanding = 8
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              req_valid_i,
   output logic                              req_ready_o,
   input  logic [31:0]                       req_insn_i,
   input  logic [XLEN-1:0]                   req_rs1_i,
   input  logic [XLEN-1:0]                   req_rs2_i,
   input  logic                              req_wb_i,
   output logic                              acc_req_valid_o,
   input  logic                              acc_req_ready_i,
   output logic [31:0]                       acc_insn_o,
   output logic [XLEN-1:0]                   acc_rs1_o,
   output logic [XLEN-1:0]                   acc_rs2_o,
   input  logic                              acc_resp_valid_i,
   output logic                              acc_resp_ready_o,
   input  logic [XLEN-1:0]                   acc_resp_result_i,
   output logic [XLEN-1:0]                   last_result_o,
   output logic [$clog2(MaxOutstanding):0]   outstanding_o,
   output logic                              idle_o,
   output logic                              resp_err_o,
   output logic [63:0]                       stall_cnt_o,
   output logic [63:0]                       block_cnt_o
);

   localparam int unsigned AddrW = $clog2(Depth);
   localparam int unsigned PtrW  = AddrW + 1;
   localparam int unsigned OutW  = $clog2(MaxOutstanding) + 1;
   localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);
   localparam logic [PtrW-1:0] CntFull = PtrW'(Depth);
   localparam logic [OutW-1:0] OutMax  = OutW'(MaxOutstanding);

   logic [31:0]      insn_mem_q [Depth];
   logic [XLEN-1:0]  rs1_mem_q  [Depth];
   logic [XLEN-1:0]  rs2_mem_q  [Depth];
   logic             wb_mem_q   [Depth];

   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt_q, cnt_d;
   logic [OutW-1:0]  out_q, out_d;
   logic             err_q, err_d, resp_rdy_q, resp_rdy_d;
   logic [XLEN-1:0]  last_q, last_d;
   logic [63:0]      stall_q, stall_d, block_q, block_d;

   logic empty, full, push, pop, head_wb, blocked, out_inc, out_dec;

   assign empty   = (cnt_q == {PtrW{1'b0}});
   assign full    = (cnt_q == CntFull);
   assign head_wb = wb_mem_q[rd_ptr_q[AddrW-1:0]];
   // A response-expecting head may not leave while every response slot is taken.
   assign blocked = !empty && head_wb && (out_q == OutMax);
   assign push    = req_valid_i && !full;
   assign pop     = acc_req_valid_o && acc_req_ready_i;
   assign out_inc = pop && head_wb;
   assign out_dec = acc_resp_valid_i && (out_q != {OutW{1'b0}});

   assign req_ready_o      = !full;
   assign acc_req_valid_o  = !empty && !blocked;
   assign acc_insn_o       = insn_mem_q[rd_ptr_q[AddrW-1:0]];
   assign acc_rs1_o        = rs1_mem_q[rd_ptr_q[AddrW-1:0]];
   assign acc_rs2_o        = rs2_mem_q[rd_ptr_q[AddrW-1:0]];
   assign acc_resp_ready_o = resp_rdy_q;
   assign last_result_o    = last_q;
   assign outstanding_o    = out_q;
   assign idle_o           = empty && (out_q == {OutW{1'b0}});
   assign resp_err_o       = err_q;
   assign stall_cnt_o      = stall_q;
   assign block_cnt_o      = block_q;

   // Next-state computation for pointers, occupancy, outstanding count and statistics.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      out_d      = out_q;
      err_d      = err_q;
      last_d     = last_q;
      stall_d    = stall_q;
      block_d    = block_q;
      resp_rdy_d = 1'b1;

      if (push) begin
         wr_ptr_d = (wr_ptr_q == PtrLast) ? {PtrW{1'b0}} : wr_ptr_q + PtrW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PtrLast) ? {PtrW{1'b0}} : rd_ptr_q + PtrW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push, pop})
         2'b10:   cnt_d = cnt_q + PtrW'(1);
         2'b01:   cnt_d = cnt_q - PtrW'(1);
         default: cnt_d = cnt_q;
      endcase

      case ({out_inc, out_dec})
         2'b10:   out_d = out_q + OutW'(1);
         2'b01:   out_d = out_q - OutW'(1);
         default: out_d = out_q;
      endcase

      if (acc_resp_valid_i) begin
         last_d = acc_resp_result_i;
         err_d  = err_q || (out_q == {OutW{1'b0}});
      end else begin
         last_d = last_q;
         err_d  = err_q;
      end

      if (acc_req_valid_o && !acc_req_ready_i) begin
         stall_d = stall_q + 64'd1;
      end else begin
         stall_d = stall_q;
      end
      if (blocked) begin
         block_d = block_q + 64'd1;
      end else begin
         block_d = block_q;
      end
   end

   // Control state registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q   <= {PtrW{1'b0}};
         rd_ptr_q   <= {PtrW{1'b0}};
         cnt_q      <= {PtrW{1'b0}};
         out_q      <= {OutW{1'b0}};
         err_q      <= 1'b0;
         last_q     <= {XLEN{1'b0}};
         stall_q    <= 64'd0;
         block_q    <= 64'd0;
         resp_rdy_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         out_q      <= out_d;
         err_q      <= err_d;
         last_q     <= last_d;
         stall_q    <= stall_d;
         block_q    <= block_d;
         resp_rdy_q <= resp_rdy_d;
      end
   end

   // Entry storage; contents are meaningless until written, so it carries no reset.
   always_ff @(posedge clk_i) begin
      if (push) begin
         insn_mem_q[wr_ptr_q[AddrW-1:0]] <= req_insn_i;
         rs1_mem_q[wr_ptr_q[AddrW-1:0]]  <= req_rs1_i;
         rs2_mem_q[wr_ptr_q[AddrW-1:0]]  <= req_rs2_i;
         wb_mem_q[wr_ptr_q[AddrW-1:0]]   <= req_wb_i;
      end
   end

endmodule

// File: tb/tb_ara_dispatch_buffer.sv
// Directed bench for ara_dispatch_buffer (Depth=4, MaxOutstanding=2).
module tb_ara_dispatch_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_wb, acc_req_ready, acc_resp_valid;
   logic [31:0] req_insn;
   logic [63:0] req_rs1, req_rs2, acc_resp_result;
   logic        req_ready, acc_req_valid, acc_resp_ready, idle, resp_err;
   logic [31:0] acc_insn;
   logic [63:0] acc_rs1, acc_rs2, last_result, stall_cnt, block_cnt;
   logic [1:0]  outstanding;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   ara_dispatch_buffer #(.Depth(4), .XLEN(64), .MaxOutstanding(2)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_insn_i(req_insn),
      .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_wb_i(req_wb),
      .acc_req_valid_o(acc_req_valid), .acc_req_ready_i(acc_req_ready),
      .acc_insn_o(acc_insn), .acc_rs1_o(acc_rs1), .acc_rs2_o(acc_rs2),
      .acc_resp_valid_i(acc_resp_valid), .acc_resp_ready_o(acc_resp_ready),
      .acc_resp_result_i(acc_resp_result), .last_result_o(last_result),
      .outstanding_o(outstanding), .idle_o(idle), .resp_err_o(resp_err),
      .stall_cnt_o(stall_cnt), .block_cnt_o(block_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_wb = 1'b0; req_insn = 32'd0;
      req_rs1 = 64'd0; req_rs2 = 64'd0; acc_req_ready = 1'b0;
      acc_resp_valid = 1'b0; acc_resp_result = 64'd0;
      tick(); tick();
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_acc_valid", 64'(acc_req_valid), 64'd0);
      chk("rst_resp_ready", 64'(acc_resp_ready), 64'd0);
      chk("rst_idle", 64'(idle), 64'd1);
      chk("rst_outstanding", 64'(outstanding), 64'd0);
      chk("rst_err", 64'(resp_err), 64'd0);
      chk("rst_last", last_result, 64'd0);
      chk("rst_stall", stall_cnt, 64'd0);
      chk("rst_block", block_cnt, 64'd0);
      rst = 1'b0;
      tick();
      chk("resp_ready_up", 64'(acc_resp_ready), 64'd1);

      // Fill with Ara stalled; a push attempt while full must be dropped.
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1; req_insn = 32'h57 + 32'(i);
         req_rs1 = 64'(i); req_rs2 = 64'(100 + i);
         tick();
      end
      chk("full_req_ready", 64'(req_ready), 64'd0);
      chk("full_stall", stall_cnt, 64'd3);
      chk("full_head", 64'(acc_insn), 64'h57);
      req_insn = 32'h99;
      tick();
      req_valid = 1'b0; acc_req_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_valid", 64'(acc_req_valid), 64'd1);
         chk("drain_insn", 64'(acc_insn), 64'h57 + 64'(i));
         chk("drain_rs1", acc_rs1, 64'(i));
         chk("drain_rs2", acc_rs2, 64'(100 + i));
         tick();
      end
      chk("drain_empty", 64'(acc_req_valid), 64'd0);
      chk("drain_idle", 64'(idle), 64'd1);
      chk("drain_stall", stall_cnt, 64'd4);

      // Streaming push+pop every cycle wraps the pointers several times.
      for (int k = 0; k <= 20; k++) begin
         if (k >= 1) begin
            chk("stream_valid", 64'(acc_req_valid), 64'd1);
            chk("stream_insn", 64'(acc_insn), 64'h1000 + 64'(k - 1));
            chk("stream_ready", 64'(req_ready), 64'd1);
            chk("stream_idle", 64'(idle), 64'd0);
         end
         req_valid = 1'b1; req_insn = 32'h1000 + 32'(k);
         tick();
      end
      req_valid = 1'b0;
      chk("stream_last", 64'(acc_insn), 64'h1014);
      tick();
      chk("stream_idle_end", 64'(idle), 64'd1);
      chk("stream_stall", stall_cnt, 64'd4);

      // Stall count over 7 cycles, then reset clears everything.
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst2_stall", stall_cnt, 64'd0);
      chk("rst2_resp_ready", 64'(acc_resp_ready), 64'd0);
      tick();
      acc_req_ready = 1'b0; req_valid = 1'b1; req_insn = 32'hAA;
      tick();
      req_valid = 1'b0;
      chk("stall_start", stall_cnt, 64'd0);
      for (int i = 0; i < 7; i++) tick();
      chk("stall_7", stall_cnt, 64'd7);
      chk("stall_hold_valid", 64'(acc_req_valid), 64'd1);
      chk("stall_hold_insn", 64'(acc_insn), 64'hAA);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst3_stall", stall_cnt, 64'd0);
      chk("rst3_valid", 64'(acc_req_valid), 64'd0);
      chk("rst3_idle", 64'(idle), 64'd1);
      chk("rst3_req_ready", 64'(req_ready), 64'd1);
      tick();

      // Outstanding limit of 2: third wb instruction is held back.
      acc_req_ready = 1'b1; req_wb = 1'b1; req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req_insn = 32'hB0 + 32'(i);
         tick();
      end
      req_valid = 1'b0;
      chk("lim_valid", 64'(acc_req_valid), 64'd0);
      chk("lim_out", 64'(outstanding), 64'd2);
      chk("lim_block0", block_cnt, 64'd0);
      tick(); tick();
      chk("lim_block2", block_cnt, 64'd2);
      chk("lim_head", 64'(acc_insn), 64'hB2);
      chk("lim_still_blocked", 64'(acc_req_valid), 64'd0);
      acc_resp_valid = 1'b1; acc_resp_result = 64'h1111;
      tick();
      acc_resp_valid = 1'b0;
      chk("lim_freed_valid", 64'(acc_req_valid), 64'd1);
      chk("lim_freed_out", 64'(outstanding), 64'd1);
      chk("lim_block3", block_cnt, 64'd3);
      chk("lim_last", last_result, 64'h1111);
      tick();
      chk("lim_reissue_out", 64'(outstanding), 64'd2);
      chk("lim_reissue_empty", 64'(acc_req_valid), 64'd0);
      chk("lim_not_idle", 64'(idle), 64'd0);
      chk("lim_block_final", block_cnt, 64'd3);

      // Pop of a wb head coincides with a response: count unchanged.
      acc_resp_valid = 1'b1; acc_resp_result = 64'h2222;
      tick();
      acc_resp_valid = 1'b0;
      chk("same_pre_out", 64'(outstanding), 64'd1);
      req_valid = 1'b1; req_insn = 32'hC0;
      tick();
      req_valid = 1'b0;
      chk("same_head_valid", 64'(acc_req_valid), 64'd1);
      acc_resp_valid = 1'b1; acc_resp_result = 64'h3333;
      tick();
      acc_resp_valid = 1'b0;
      chk("same_out", 64'(outstanding), 64'd1);
      chk("same_last", last_result, 64'h3333);
      chk("same_popped", 64'(acc_req_valid), 64'd0);
      acc_resp_valid = 1'b1; acc_resp_result = 64'h4444;
      tick();
      acc_resp_valid = 1'b0;
      chk("drain_out0", 64'(outstanding), 64'd0);
      chk("drain_idle2", 64'(idle), 64'd1);
      chk("no_err_yet", 64'(resp_err), 64'd0);

      // Unexpected response sets the sticky error.
      acc_resp_valid = 1'b1; acc_resp_result = 64'hDEAD;
      tick();
      acc_resp_valid = 1'b0;
      chk("err_set", 64'(resp_err), 64'd1);
      chk("err_out", 64'(outstanding), 64'd0);
      chk("err_last", last_result, 64'hDEAD);
      tick(); tick();
      chk("err_sticky", 64'(resp_err), 64'd1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("err_cleared", 64'(resp_err), 64'd0);
      chk("last_cleared", last_result, 64'd0);
      chk("block_cleared", block_cnt, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
